// File: rtl/booth_mul_pipe.sv
// booth_mul_pipe: pipelined radix-4 Booth multiplier, per-op signed/unsigned, tag sideband.
// Latency: 3 register stages; a pair accepted at edge N shows out_valid after edge N+2.
// Backpressure: out_valid && !out_ready freezes every stage and drops in_ready (global stall).
// Optional accumulator: define BOOTH_MUL_ACC_EN to add acc_en/acc_clr/ACC.

module booth_mul_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 sgn,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   P,
  output logic [TAG_W-1:0]     out_tag
`ifdef BOOTH_MUL_ACC_EN
  ,
  input  logic                 acc_en,
  input  logic                 acc_clr,
  output logic [2*WIDTH+7:0]   ACC
`endif
);

  // Product width, extended-operand width, Booth row count, rows incl. correction row.
  localparam int PW   = 2 * WIDTH;
  localparam int EW   = WIDTH + 2;
  localparam int NPP  = WIDTH / 2 + 1;
  localparam int NROW = NPP + 1;

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------
  logic                 r_s1_vld;
  logic [PW-1:0]        r_s1_pp [NPP];
  logic [NPP-1:0]       r_s1_neg;
  logic [TAG_W-1:0]     r_s1_tag;

  logic                 r_s2_vld;
  logic [PW-1:0]        r_s2_sum;
  logic [PW-1:0]        r_s2_car;
  logic [TAG_W-1:0]     r_s2_tag;

  logic                 r_out_vld;
  logic [PW-1:0]        r_p;
  logic [TAG_W-1:0]     r_out_tag;

`ifdef BOOTH_MUL_ACC_EN
  // Signedness and accumulate-enable only matter at retirement, so they ride along.
  logic                 r_s1_sgn;
  logic                 r_s1_acc;
  logic                 r_s2_sgn;
  logic                 r_s2_acc;
  logic                 r_s3_sgn;
  logic                 r_s3_acc;
`endif

  // ---------------------------------------------------------------------------
  // Flow control: one global advance enable; a held output freezes everything.
  // in_ready depends only on registered state and out_ready, never on in_valid.
  // ---------------------------------------------------------------------------
  logic w_adv;

  assign w_adv     = !(r_out_vld && !out_ready);
  assign in_ready  = w_adv;
  assign out_valid = r_out_vld;
  assign P         = r_p;
  assign out_tag   = r_out_tag;

  // ---------------------------------------------------------------------------
  // Stage 1 datapath: extend operands to WIDTH+2 bits and Booth-encode B.
  // A is carried at full product width so every row is already sign-correct.
  // ---------------------------------------------------------------------------
  logic [PW-1:0]  w_a_ext;
  logic [1:0]     w_b_hi;
  logic [EW:0]    w_b_pad;   // extended B with the implicit b[-1] = 0 below bit 0
  logic [PW-1:0]  w_pp [NPP];
  logic [NPP-1:0] w_neg;

  assign w_a_ext = sgn ? {{(PW-WIDTH){A[WIDTH-1]}}, A} : {{(PW-WIDTH){1'b0}}, A};
  assign w_b_hi  = sgn ? {2{B[WIDTH-1]}} : 2'b00;
  assign w_b_pad = {w_b_hi, B, 1'b0};

  for (genvar g = 0; g < NPP; g++) begin : g_enc
    logic [2:0]    w_trip;
    logic          w_one;
    logic          w_two;
    logic [PW-1:0] w_mag;

    // Overlapping triplet {b[2g+1], b[2g], b[2g-1]} selects the digit.
    assign w_trip   = w_b_pad[2*g+2 : 2*g];
    assign w_one    = w_trip[1] ^ w_trip[0];
    assign w_two    = (w_trip == 3'b011) || (w_trip == 3'b100);
    // 111 encodes zero; treating it as non-negative avoids a useless correction.
    assign w_neg[g] = w_trip[2] && !(w_trip[1] && w_trip[0]);
    assign w_mag    = w_two ? {w_a_ext[PW-2:0], 1'b0} : (w_one ? w_a_ext : '0);
    // Negative rows hold the one's complement; the +1 goes into the correction row.
    assign w_pp[g]  = (w_neg[g] ? ~w_mag : w_mag) << (2 * g);
  end

  // Stage 1 registers: Booth rows, negate flags and sideband of an accepted pair.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1_pp  <= '{default: '0};
      r_s1_neg <= '0;
      r_s1_tag <= '0;
`ifdef BOOTH_MUL_ACC_EN
      r_s1_sgn <= 1'b0;
      r_s1_acc <= 1'b0;
`endif
    end else if (w_adv) begin
      r_s1_vld <= in_valid;
      if (in_valid) begin
        r_s1_pp  <= w_pp;
        r_s1_neg <= w_neg;
        r_s1_tag <= in_tag;
`ifdef BOOTH_MUL_ACC_EN
        r_s1_sgn <= sgn;
        r_s1_acc <= acc_en;
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 datapath: collect the negate bits into one correction row (bit 2g
  // of row g is always zero-free of overlap) and reduce all rows with a 3:2
  // carry-save chain. The carry shifted out of the top is discarded, which is
  // exactly the modulo 2^(2*WIDTH) truncation of the product.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] w_cor;
  logic [PW-1:0] w_row  [NROW];
  logic [PW-1:0] w_cs_s [NROW+1];
  logic [PW-1:0] w_cs_c [NROW+1];

  for (genvar g = 0; g < NPP; g++) begin : g_cor
    assign w_cor[2*g]   = r_s1_neg[g];
    assign w_cor[2*g+1] = 1'b0;
    assign w_row[g]     = r_s1_pp[g];
  end
  assign w_cor[PW-1:2*NPP] = '0;
  assign w_row[NPP]        = w_cor;

  assign w_cs_s[0] = '0;
  assign w_cs_c[0] = '0;

  for (genvar g = 0; g < NROW; g++) begin : g_csa
    assign w_cs_s[g+1] = w_cs_s[g] ^ w_cs_c[g] ^ w_row[g];
    assign w_cs_c[g+1] = ((w_cs_s[g] & w_cs_c[g]) |
                          (w_cs_s[g] & w_row[g])  |
                          (w_cs_c[g] & w_row[g])) << 1;
  end

  // Stage 2 registers: carry-save pair plus sideband.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_s2_vld <= 1'b0;
      r_s2_sum <= '0;
      r_s2_car <= '0;
      r_s2_tag <= '0;
`ifdef BOOTH_MUL_ACC_EN
      r_s2_sgn <= 1'b0;
      r_s2_acc <= 1'b0;
`endif
    end else if (w_adv) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_sum <= w_cs_s[NROW];
        r_s2_car <= w_cs_c[NROW];
        r_s2_tag <= r_s1_tag;
`ifdef BOOTH_MUL_ACC_EN
        r_s2_sgn <= r_s1_sgn;
        r_s2_acc <= r_s1_acc;
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: carry-propagate add into the output register.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] w_sum_final;

  assign w_sum_final = r_s2_sum + r_s2_car;

  // Output register: loads only real results, so bubbles leave P/out_tag untouched.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_out_vld <= 1'b0;
      r_p       <= '0;
      r_out_tag <= '0;
`ifdef BOOTH_MUL_ACC_EN
      r_s3_sgn  <= 1'b0;
      r_s3_acc  <= 1'b0;
`endif
    end else if (w_adv) begin
      r_out_vld <= r_s2_vld;
      if (r_s2_vld) begin
        r_p       <= w_sum_final;
        r_out_tag <= r_s2_tag;
`ifdef BOOTH_MUL_ACC_EN
        r_s3_sgn  <= r_s2_sgn;
        r_s3_acc  <= r_s2_acc;
`endif
      end
    end
  end

`ifdef BOOTH_MUL_ACC_EN
  // ---------------------------------------------------------------------------
  // Accumulator: adds each retiring product flagged at issue, extended by its
  // own signedness; wraps modulo 2^(2*WIDTH+8).
  // ---------------------------------------------------------------------------
  localparam int AW = PW + 8;

  logic [AW-1:0] r_acc;
  logic [AW-1:0] w_p_ext;
  logic          w_retire_acc;

  assign w_p_ext      = r_s3_sgn ? {{8{r_p[PW-1]}}, r_p} : {8'b0, r_p};
  assign w_retire_acc = r_out_vld && out_ready && r_s3_acc;
  assign ACC          = r_acc;

  // Accumulate on retirement; acc_clr restarts from this product, or from zero if none retires.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_acc <= '0;
    end else if (w_retire_acc) begin
      r_acc <= acc_clr ? w_p_ext : (r_acc + w_p_ext);
    end else if (acc_clr) begin
      r_acc <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_booth_mul_pipe.sv
// tb_booth_mul_pipe: self-checking bench for booth_mul_pipe (WIDTH=32, TAG_W=4).
// Table vectors with spec-given products, random streaming against an arithmetic
// model, a forced stall, reset with work in flight, and the accumulator when built in.

module tb_booth_mul_pipe;

  localparam int WIDTH = 32;
  localparam int TAG_W = 4;
  localparam int PW    = 2 * WIDTH;
  localparam int NV    = 10;

  logic              sys_clk   = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              in_valid  = 1'b0;
  logic              sgn       = 1'b0;
  logic [WIDTH-1:0]  A         = '0;
  logic [WIDTH-1:0]  B         = '0;
  logic [TAG_W-1:0]  in_tag    = '0;
  logic              out_ready = 1'b1;
  logic              in_ready;
  logic              out_valid;
  logic [PW-1:0]     P;
  logic [TAG_W-1:0]  out_tag;
`ifdef BOOTH_MUL_ACC_EN
  logic              acc_en    = 1'b0;
  logic              acc_clr   = 1'b0;
  logic [PW+7:0]     ACC;
`endif

  booth_mul_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sgn       (sgn),
    .A         (A),
    .B         (B),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .P         (P),
    .out_tag   (out_tag)
`ifdef BOOTH_MUL_ACC_EN
    ,
    .acc_en    (acc_en),
    .acc_clr   (acc_clr),
    .ACC       (ACC)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic             s;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAG_W-1:0] tag;
    logic [PW-1:0]    p;
  } vec_t;

  typedef struct {
    logic [PW-1:0]    p;
    logic [TAG_W-1:0] tag;
  } exp_t;

  vec_t vt [NV];
  exp_t q [$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_out    = 0;
  int n_in     = 0;
  int n_stall  = 0;

  logic             prev_stall = 1'b0;
  logic [PW-1:0]    held_p     = '0;
  logic [TAG_W-1:0] held_tag   = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Exact product of the operands as plain integers, truncated to 2*WIDTH bits.
  function automatic logic [PW-1:0] ref_mul(input logic s, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic signed [PW-1:0] sa;
    logic signed [PW-1:0] sb;
    if (s) begin
      sa = {{WIDTH{a[WIDTH-1]}}, a};
      sb = {{WIDTH{b[WIDTH-1]}}, b};
      return sa * sb;
    end
    return {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  endfunction

  function automatic logic [WIDTH-1:0] pick_op();
    logic [WIDTH-1:0] r;
    case ($urandom_range(0, 7))
      0:       r = '0;
      1:       r = 32'h8000_0000;
      2:       r = 32'hFFFF_FFFF;
      3:       r = 32'h7FFF_FFFF;
      4:       r = 32'h0000_0001;
      default: r = $urandom;
    endcase
    return r;
  endfunction

  // One isolated transaction from an idle pipe: latency, value, tag, and the trailing bubble.
  task automatic apply_vec(input vec_t v, input int idx);
    out_ready = 1'b1;
    sgn = v.s; A = v.a; B = v.b; in_tag = v.tag; in_valid = 1'b1;
    #1;
    chk($sformatf("vec%0d_in_ready", idx), in_ready, 1'b1);
    @(posedge sys_clk); @(negedge sys_clk);
    in_valid = 1'b0;
    chk($sformatf("vec%0d_vld_edge1", idx), out_valid, 1'b0);
    @(posedge sys_clk); @(negedge sys_clk);
    chk($sformatf("vec%0d_vld_edge2", idx), out_valid, 1'b0);
    @(posedge sys_clk); @(negedge sys_clk);
    chk($sformatf("vec%0d_vld_edge3", idx), out_valid, 1'b1);
    chk($sformatf("vec%0d_P", idx), P, v.p);
    chk($sformatf("vec%0d_tag", idx), out_tag, v.tag);
    @(posedge sys_clk); @(negedge sys_clk);
    chk($sformatf("vec%0d_bubble", idx), out_valid, 1'b0);
  endtask

  // One clock of streaming, entered and left at a falling edge; scoreboards outputs.
  task automatic step(input bit drive, input bit ordy);
    exp_t e;
    out_ready = ordy;
    #1;
    if (prev_stall) begin
      chk("stall_vld_held", out_valid, 1'b1);
      chk("stall_P_stable", P, held_p);
      chk("stall_tag_stable", out_tag, held_tag);
    end
    chk("in_ready_rule", in_ready, !(out_valid && !ordy));
    if (out_valid && ordy) begin
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_out: out_valid=1 tag=0x%0h with nothing outstanding", out_tag);
      end else begin
        e = q.pop_front();
        chk("stream_P", P, e.p);
        chk("stream_tag", out_tag, e.tag);
      end
      n_out++;
    end
    if (out_valid && !ordy) n_stall++;
    prev_stall = out_valid && !ordy;
    held_p     = P;
    held_tag   = out_tag;
    if (drive) begin
      sgn      = 1'($urandom_range(0, 1));
      A        = pick_op();
      B        = pick_op();
      in_tag   = 4'($urandom_range(0, 15));
      in_valid = 1'b1;
      if (in_ready) begin
        e.p   = ref_mul(sgn, A, B);
        e.tag = in_tag;
        q.push_back(e);
        n_in++;
      end
    end else begin
      in_valid = 1'b0;
    end
    @(posedge sys_clk); @(negedge sys_clk);
  endtask

`ifdef BOOTH_MUL_ACC_EN
  // Issue one accumulate-enabled product, optionally clear on its retiring edge, then check ACC.
  task automatic acc_op(input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic clr, input logic [PW+7:0] exp, input int idx);
    out_ready = 1'b1;
    sgn = s; A = a; B = b; in_tag = 4'(idx); acc_en = 1'b1; in_valid = 1'b1;
    @(posedge sys_clk); @(negedge sys_clk);
    in_valid = 1'b0; acc_en = 1'b0;
    @(posedge sys_clk); @(negedge sys_clk);
    @(posedge sys_clk); @(negedge sys_clk);
    acc_clr = clr;
    @(posedge sys_clk); @(negedge sys_clk);
    acc_clr = 1'b0;
    chk($sformatf("acc_step%0d", idx), ACC, exp);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vt[0] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5,  64'hFFFF_FFFE_0000_0001};
    vt[1] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd6,  64'h0000_0000_0000_0001};
    vt[2] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 4'd7,  64'h4000_0000_0000_0000};
    vt[3] = '{1'b1, 32'h8000_0000, 32'h0000_0002, 4'd8,  64'hFFFF_FFFF_0000_0000};
    vt[4] = '{1'b0, 32'h8000_0000, 32'h0000_0002, 4'd9,  64'h0000_0001_0000_0000};
    vt[5] = '{1'b1, 32'h0000_0000, 32'h7FFF_FFFF, 4'd10, 64'h0000_0000_0000_0000};
    vt[6] = '{1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'd11, 64'h3FFF_FFFF_0000_0001};
    vt[7] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0003, 4'd12, 64'hFFFF_FFFF_FFFF_FFFD};
    vt[8] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0003, 4'd13, 64'h0000_0002_FFFF_FFFD};
    vt[9] = '{1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 4'd14, 64'hFFFF_FFFF_EDCB_A988};

    // Reset state
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_P", P, 64'h0);
    chk("rst_out_tag", out_tag, 4'h0);
    chk("rst_in_ready", in_ready, 1'b1);
`ifdef BOOTH_MUL_ACC_EN
    chk("rst_ACC", ACC, 72'h0);
`endif
    sys_rst_n = 1'b1;
    @(posedge sys_clk); @(negedge sys_clk);

    // Directed vectors, one at a time
    for (int i = 0; i < NV; i++) apply_vec(vt[i], i);

    // Back-to-back random stream with out_ready held high
    n_out = 0; n_in = 0;
    for (int k = 0; k < 2000; k++) step(1'b1, 1'b1);
    chk("stream_throughput", n_out, 1997);
    for (int k = 0; k < 10 && q.size() > 0; k++) step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    chk("stream_count", n_out, 2000);
    chk("stream_accepted", n_in, 2000);
    chk("stream_left", q.size(), 0);

    // Stream with a 5-cycle forced stall mid-burst, then random backpressure
    n_out = 0; n_in = 0; n_stall = 0;
    for (int k = 0; k < 60; k++) begin
      bit d;
      bit r;
      d = (k < 25) ? 1'b1 : ($urandom_range(0, 3) != 0);
      r = (k >= 12 && k < 17) ? 1'b0 : ((k < 30) ? 1'b1 : ($urandom_range(0, 3) != 0));
      step(d, r);
    end
    for (int k = 0; k < 30 && q.size() > 0; k++) step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    chk("bp_in_eq_out", n_out, n_in);
    chk("bp_left", q.size(), 0);
    chk("bp_stall_seen", n_stall >= 5, 1'b1);

    // Reset with three transactions in flight
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sgn = 1'b0; A = 32'(i + 2); B = 32'd3; in_tag = 4'(i + 1); in_valid = 1'b1;
      @(posedge sys_clk); @(negedge sys_clk);
    end
    in_valid = 1'b0;
    #1;
    chk("rst_mid_pre_vld", out_valid, 1'b1);
    sys_rst_n = 1'b0;
    #1;
    chk("rst_mid_vld", out_valid, 1'b0);
    chk("rst_mid_P", P, 64'h0);
    chk("rst_mid_tag", out_tag, 4'h0);
    @(posedge sys_clk); @(negedge sys_clk);
    sys_rst_n  = 1'b1;
    prev_stall = 1'b0;
    q.delete();
    for (int i = 0; i < 6; i++) begin
      @(posedge sys_clk); @(negedge sys_clk);
      chk($sformatf("post_rst_idle%0d", i), out_valid, 1'b0);
    end
    apply_vec(vt[3], 100);

`ifdef BOOTH_MUL_ACC_EN
    // Accumulator sequence
    chk("acc_start", ACC, 72'h0);
    acc_op(1'b1, 32'd3, 32'd4, 1'b0, 72'd12, 1);
    acc_op(1'b1, 32'd5, 32'd6, 1'b0, 72'd42, 2);
    acc_op(1'b1, 32'hFFFF_FFFE, 32'd7, 1'b0, 72'd28, 3);
    acc_op(1'b1, 32'd1, 32'd1, 1'b1, 72'd1, 4);
    acc_clr = 1'b1;
    @(posedge sys_clk); @(negedge sys_clk);
    acc_clr = 1'b0;
    chk("acc_clear_idle", ACC, 72'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/booth_mul_pipe.md
Name: booth_mul_pipe

Overview:
Parametrised, fully pipelined radix-4 Booth multiplier with valid/ready handshake, run-time signed/unsigned selection per operation, and a sideband tag carried alongside each product. It is the next-generation replacement for the fixed 32x32 Booth_mul. It sits between an operand-issue stage and a result-writeback stage. Throughput is one product per clock when not back-pressured.

Parameters:
WIDTH, 32, operand width in bits; must be even and at least 4.
TAG_W, 4, width of the sideband tag passed through with each product.

Ports:
sys_clk  input  1  clock, all logic on the rising edge
sys_rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair present
in_ready  output  1  block can accept an operand pair this cycle
sgn  input  1  1 = A and B are two's complement; 0 = both unsigned
A  input  WIDTH  multiplicand
B  input  WIDTH  multiplier
in_tag  input  TAG_W  sideband tag, returned unchanged with the result
out_valid  output  1  P and out_tag are valid
out_ready  input  1  downstream accepts the result this cycle
P  output  2*WIDTH  product
out_tag  output  TAG_W  tag of this product

Behaviour:
- One clock (sys_clk). Reset is asynchronous and active-low on sys_rst_n, with synchronous deassertion handled upstream.
- Reset values: every stage valid bit = 0, out_valid = 0, P = 0, out_tag = 0, and all internal data registers = 0.
- Acceptance: an operand pair is accepted on a rising edge where in_valid && in_ready.
- in_ready = !(out_valid && !out_ready). This is a global stall: when the output is held, all stages freeze. in_ready has no combinational path from in_valid.
- Pipeline has 3 register stages:
  - S1: Booth-encode B, then register the partial products plus the sgn and tag bits.
  - S2: reduce the partial products to a registered carry-save pair.
  - S3: final carry-propagate add into P and out_tag.
- Latency: a pair accepted at edge N is presented with out_valid = 1 after edge N+2, provided there is no stall.
- Stall: while out_valid && !out_ready, all stage registers and valid bits hold. P and out_tag must not change.
- Bubbles: stage valid bits propagate independently. A bubble never produces out_valid.
- Throughput: with out_ready held at 1, back-to-back inputs give back-to-back outputs, in order.
- Arithmetic:
  - Extend operands to WIDTH+2 bits: sign-extend when sgn = 1, zero-extend when sgn = 0.
  - Use radix-4 Booth on the extended B, giving WIDTH/2+1 partial products, each a multiple of A in {-2,-1,0,+1,+2}.
  - Negation uses one's complement plus a correction bit in the row.
  - P = the low 2*WIDTH bits of the exact product. This is exact for both modes.
- sgn is captured per transaction at acceptance. Mixed-mode back-to-back operations must each be correct.
- Reset mid-operation: all in-flight results are discarded and out_valid drops immediately, because the reset is asynchronous. No stale result may appear after reset is released.

Optional Feature:
BOOTH_MUL_ACC_EN
- When defined, the following are added:
  - input acc_en (1): accumulate this result.
  - input acc_clr (1): clear the accumulator.
  - output ACC (2*WIDTH+8): accumulator value.
- ACC resets to 0.
- When a result leaves S3 (out_valid && out_ready) with the acc_en it was issued with (captured at acceptance and piped alongside the tag):
  - ACC <= ACC + P, with P sign-extended if its sgn was 1, otherwise zero-extended.
  - If acc_clr is also set, ACC <= extended P.
- acc_clr with no retiring accumulate sets ACC <= 0.
- Wrap-around modulo 2^(2*WIDTH+8); no saturation.
- When the macro is undefined, these ports and this logic do not exist, and the behaviour is otherwise identical.

Test Plan:
- Reset, then one transaction with WIDTH=32, sgn=0, A=0xFFFFFFFF, B=0xFFFFFFFF, tag=5 -> out_valid after 3 edges, P=0xFFFFFFFE00000001, out_tag=5.
- Same operands with sgn=1 -> P=0x0000000000000001. Then A=B=0x80000000 with sgn=1 -> P=0x4000000000000000. Then A=0x80000000, B=0x00000002 with sgn=1 -> P=0xFFFFFFFF00000000.
- Back-to-back streaming: 2000 random pairs with random sgn, out_ready=1 -> one result per cycle, in-order tags, each P equal to the reference signed or unsigned product.
- Backpressure: stream with out_ready low for 5 cycles mid-burst -> in_ready=0 during the stall, P/out_tag stable, no loss or duplication, order preserved.
- Reset asserted with 3 transactions in flight -> out_valid=0 immediately. After release, no output appears until new inputs are accepted.
- With BOOTH_MUL_ACC_EN: products 3*4, 5*6, (-2)*7 signed, all with acc_en=1 -> ACC=12, 42, 28. Then acc_clr on the next retire with 1*1 -> ACC=1.
